// File: rtl/nonce_search_engine.sv
// ============================================================================
// Module      : nonce_search_engine
// Description : Block build, micro-hash and target compare with nonce search.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nonce_search_engine #(
  parameter int NONCE_BYTES = 4,
  parameter int UNROLL      = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode,
  input  logic                          abort,
  input  logic [8*(16-NONCE_BYTES)-1:0] entry,
  input  logic [8*NONCE_BYTES-1:0]      nonce_init,
  input  logic [7:0]                    target,
  input  logic [8*NONCE_BYTES-1:0]      max_tries,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [8*NONCE_BYTES-1:0]      nonce_out,
  output logic [23:0]                   hash_out,
  output logic [8*NONCE_BYTES-1:0]      tries
);

  localparam int ENTRY_BYTES = 16 - NONCE_BYTES;
  localparam int NW          = 8 * NONCE_BYTES;
  localparam logic [5:0] c_last_round = 6'(32 - UNROLL);
  localparam logic [5:0] c_step       = 6'(UNROLL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  logic [8*ENTRY_BYTES-1:0] r_entry;
  logic [NW-1:0]          r_nonce;
  logic                   r_mode;
  logic [7:0]             r_target;
  logic [NW-1:0]          r_budget;
  logic [NW-1:0]          r_count;
  logic                   r_abort;
  logic [7:0]             r_win [16];
  logic [7:0]             r_a, r_b, r_c;
  logic [5:0]             r_round;

  logic [7:0]             w_win [16];
  logic [7:0]             w_a, w_b, w_c;
  logic [127:0]           w_block;
  logic [7:0]             w_h0, w_h1, w_h2;
  logic                   w_pass;
  logic [NW-1:0]          w_count_next;
  logic                   w_last;

  // UNROLL rounds chained per clock; the window always holds W[i..i+15].
  always_comb begin : p_rounds
    logic [7:0] w_x, w_k, w_new, w_cn;
    logic [5:0] w_idx;
    w_a   = r_a;
    w_b   = r_b;
    w_c   = r_c;
    w_win = r_win;
    for (int j = 0; j < UNROLL; j++) begin
      w_idx = r_round + 6'(j);
      if (w_idx <= 6'd16) begin
        w_x = w_a ^ w_b;
        w_k = 8'h99;
      end else begin
        w_x = w_a | w_b;
        w_k = 8'hA1;
      end
      w_new = w_win[13] | (w_win[7] ^ w_win[2]);
      w_cn  = w_x + w_k + w_win[0];
      w_a   = w_b ^ w_c;
      w_b   = {w_c[3:0], 4'h0};
      w_c   = w_cn;
      for (int m = 0; m < 15; m++) w_win[m] = w_win[m+1];
      w_win[15] = w_new;
    end
  end

  assign w_block      = {r_entry, r_nonce};
  assign w_h0         = 8'h01 + r_a;
  assign w_h1         = 8'h89 + r_b;
  assign w_h2         = 8'hFE + r_c;
  assign w_pass       = (w_h0 < r_target) && (w_h1 < r_target);
  assign w_count_next = r_count + NW'(1);
  assign w_last       = (w_count_next == r_budget);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_entry   <= '0;
      r_nonce   <= '0;
      r_mode    <= 1'b0;
      r_target  <= '0;
      r_budget  <= '0;
      r_count   <= '0;
      r_abort   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_round   <= '0;
      for (int m = 0; m < 16; m++) r_win[m] <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      nonce_out <= '0;
      hash_out  <= '0;
      tries     <= '0;
    end else begin
      busy <= (r_state == S_LOAD) || (r_state == S_ROUND) || (r_state == S_CHECK);
      done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_entry  <= entry;
            r_nonce  <= nonce_init;
            r_mode   <= mode;
            r_target <= target;
            r_budget <= (max_tries == '0) ? NW'(1) : max_tries;
            r_count  <= '0;
            r_abort  <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int m = 0; m < 16; m++) r_win[m] <= w_block[8*(15-m) +: 8];
          r_a     <= 8'h01;
          r_b     <= 8'h89;
          r_c     <= 8'hFE;
          r_round <= '0;
          if (abort) r_abort <= 1'b1;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_win   <= w_win;
          r_a     <= w_a;
          r_b     <= w_b;
          r_c     <= w_c;
          r_round <= r_round + c_step;
          if (abort) r_abort <= 1'b1;
          if (r_round == c_last_round) r_state <= S_CHECK;
        end
        S_CHECK: begin
          hash_out  <= {w_h0, w_h1, w_h2};
          nonce_out <= r_nonce;
          tries     <= w_count_next;
          found     <= w_pass;
          r_count   <= w_count_next;
          if (w_pass || !r_mode || w_last || r_abort) begin
            r_state <= S_DONE;
          end else begin
            r_nonce <= r_nonce + NW'(1);
            r_state <= S_LOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nonce_search_engine.sv
// ============================================================================
// Module      : tb_nonce_search_engine
// Description : Self-checking bench for nonce_search_engine (UNROLL 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nonce_search_engine;

  localparam int P1 = 34;
  localparam int P4 = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic [95:0] entry = '0;
  logic [31:0] nonce_init = '0;
  logic [7:0]  target = '0;
  logic [31:0] max_tries = '0;

  logic        busy1, done1, found1, busy4, done4, found4;
  logic [31:0] nonce1, tries1, nonce4, tries4;
  logic [23:0] hash1, hash4;

  int checks = 0;
  int errors = 0;

  nonce_search_engine #(.NONCE_BYTES(4), .UNROLL(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .entry(entry), .nonce_init(nonce_init), .target(target), .max_tries(max_tries),
    .busy(busy1), .done(done1), .found(found1), .nonce_out(nonce1),
    .hash_out(hash1), .tries(tries1)
  );

  nonce_search_engine #(.NONCE_BYTES(4), .UNROLL(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .entry(entry), .nonce_init(nonce_init), .target(target), .max_tries(max_tries),
    .busy(busy4), .done(done4), .found(found4), .nonce_out(nonce4),
    .hash_out(hash4), .tries(tries4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference hash: full 32-byte message schedule, then 32 rounds.
  function automatic logic [23:0] model_hash(input logic [95:0] e, input logic [31:0] n);
    logic [7:0]   w [32];
    logic [127:0] blk;
    logic [7:0]   a, b, c, x, k, ta;
    blk = {e, n};
    for (int i = 0; i < 16; i++) w[i] = blk[127-8*i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin x = a ^ b; k = 8'h99; end
      else         begin x = a | b; k = 8'hA1; end
      ta = b ^ c;
      b  = c << 4;
      c  = x + k + w[i];
      a  = ta;
    end
    return {8'h01 + a, 8'h89 + b, 8'hFE + c};
  endfunction

  task automatic run_model(input logic m, input logic [95:0] e, input logic [31:0] n,
                           input logic [7:0] t, input logic [31:0] mt,
                           output logic f, output logic [31:0] nn,
                           output logic [31:0] tr, output logic [23:0] h);
    logic [31:0] budget;
    budget = (mt == 0) ? 32'd1 : mt;
    nn = n;
    tr = 0;
    while (1'b1) begin
      tr++;
      h = model_hash(e, nn);
      f = (h[23:16] < t) && (h[15:8] < t);
      if (f || !m || tr == budget) break;
      nn++;
    end
  endtask

  task automatic run_op(input logic m, input logic [95:0] e, input logic [31:0] n,
                        input logic [7:0] t, input logic [31:0] mt, input int limit,
                        input int abort_edge, input int s1, input int s2,
                        output int d1, output int d4);
    @(negedge clk);
    start = 1'b1; mode = m; entry = e; nonce_init = n; target = t; max_tries = mt; abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Scramble captured inputs: the engine must ignore them from here on.
    start = (s1 == 1) || (s2 == 1);
    mode = ~m; entry = ~e; nonce_init = $urandom; target = ~t; max_tries = $urandom;
    abort = (abort_edge == 1);
    d1 = -1;
    d4 = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("busy_after_edge1", busy1, 1);
      if (done4 && d4 < 0) d4 = k;
      if (d1 >= 0) begin
        chk("done_one_cycle", done1, 0);
        break;
      end
      if (done1) begin
        d1 = k;
        chk("busy_low_in_done", busy1, 0);
      end
      @(negedge clk);
      start = (k + 1 == s1) || (k + 1 == s2);
      abort = (k + 1 == abort_edge);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic scenario(input string nm, input logic m, input logic [95:0] e,
                          input logic [31:0] n, input logic [7:0] t, input logic [31:0] mt,
                          input logic [31:0] mt_model, input int abort_edge,
                          input int s1, input int s2, input bit chk4);
    logic        f;
    logic [31:0] nn, tr;
    logic [23:0] h;
    int          d1, d4;
    run_model(m, e, n, t, mt_model, f, nn, tr, h);
    run_op(m, e, n, t, mt, int'(tr) * P1 + 40, abort_edge, s1, s2, d1, d4);
    chk({nm, ".done_edge"}, d1, int'(tr) * P1 + 1);
    chk({nm, ".found"}, found1, f);
    chk({nm, ".nonce_out"}, nonce1, nn);
    chk({nm, ".hash_out"}, hash1, h);
    chk({nm, ".tries"}, tries1, tr);
    if (chk4) begin
      chk({nm, ".u4.done_edge"}, d4, int'(tr) * P4 + 1);
      chk({nm, ".u4.found"}, found4, f);
      chk({nm, ".u4.nonce_out"}, nonce4, nn);
      chk({nm, ".u4.hash_out"}, hash4, h);
      chk({nm, ".u4.tries"}, tries4, tr);
    end
  endtask

  function automatic logic [95:0] rand_entry();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy1, 0);
    chk("rst.done", done1, 0);
    chk("rst.found", found1, 0);
    chk("rst.nonce_out", nonce1, 0);
    chk("rst.hash_out", hash1, 0);
    chk("rst.tries", tries1, 0);
    chk("rst.u4.busy", busy4, 0);
    chk("rst.u4.tries", tries4, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++)
      scenario("single", 1'b0, rand_entry(), $urandom, 8'h80, $urandom, 32'd1, -1, -1, -1, 1'b1);
    scenario("zero_budget", 1'b1, rand_entry(), $urandom, 8'h00, 32'd0, 32'd0, -1, -1, -1, 1'b1);

    // Reset asserted in the middle of a search.
    @(negedge clk);
    start = 1'b1; mode = 1'b1; target = 8'h00; max_tries = 32'd200;
    entry = rand_entry(); nonce_init = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_reset.busy", busy1, 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst.busy", busy1, 0);
      chk("mid_rst.done", done1, 0);
      chk("mid_rst.found", found1, 0);
      chk("mid_rst.nonce_out", nonce1, 0);
      chk("mid_rst.hash_out", hash1, 0);
      chk("mid_rst.tries", tries1, 0);
      chk("mid_rst.u4.busy", busy4, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    scenario("reset_recover", 1'b0, rand_entry(), $urandom, 8'h80, 32'd1, 32'd1, -1, -1, -1, 1'b1);

    scenario("budget", 1'b1, rand_entry(), 32'h0000_0010, 8'h00, 32'd5, 32'd5, -1, -1, -1, 1'b0);
    scenario("wrap", 1'b1, rand_entry(), 32'hFFFF_FFFF, 8'h00, 32'd3, 32'd3, -1, -1, -1, 1'b0);
    scenario("hit_ff", 1'b1, rand_entry(), $urandom, 8'hFF, 32'd1000, 32'd1000, -1, 5, 8, 1'b0);
    for (int i = 0; i < 2; i++)
      scenario("hit_search", 1'b1, rand_entry(), $urandom, 8'h60, 32'd1000, 32'd1000, -1, -1, -1, 1'b0);
    // Abort sampled at edge 80, inside the rounds of attempt 3.
    scenario("abort", 1'b1, rand_entry(), $urandom, 8'h00, 32'd6, 32'd3, 80, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nonce_search_engine.md
# nonce_search_engine

Parametrised nonce-search engine for the micro-hash proof-of-work flow. It merges block concatenation, the micro-hash core and the target comparison into one sequential unit with a start/done handshake. In search mode it iterates the nonce autonomously until a hash meets the target, the attempt budget is exhausted, or the host aborts. It sits between the stimulus/system controller and the result checker, replacing separate concatenator and hash instances.

## Interface
- NONCE_BYTES, 4: nonce length in bytes; legal 1..8; entry length is ENTRY_BYTES = 16 - NONCE_BYTES.
- UNROLL, 1: hash rounds evaluated per clock; legal 1, 2, 4, 8.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; 0 clears all state on the next edge.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = single hash of nonce_init; 1 = search.
- abort  in  1  stops a running search.
- entry  in  8*ENTRY_BYTES  header bytes; MSB byte is W[0].
- nonce_init  in  8*NONCE_BYTES  first nonce tried.
- target  in  8  difficulty threshold.
- max_tries  in  8*NONCE_BYTES  attempt budget; 0 treated as 1.
- busy  out  1  high from the edge after start until done.
- done  out  1  one-cycle pulse at end of operation.
- found  out  1  last attempt met target; held until next start.
- nonce_out  out  8*NONCE_BYTES  nonce of last attempt; held.
- hash_out  out  24  {H0,H1,H2} of last attempt; held.
- tries  out  8*NONCE_BYTES  attempts completed; held.

## Operation
- entry, nonce_init, mode, target and max_tries are captured at start; later changes are ignored until the next start.
- Block is W[0..15] = entry bytes MSB-first, then nonce bytes MSB-first.
- Expansion: W[i] = W[i-3] | (W[i-9] ^ W[i-14]) for i = 16..31, computed on the fly from a 16-byte sliding window.
- Hash: a,b,c start at 0x01, 0x89, 0xFE. For rounds i = 0..31:
  - If i <= 16: k = 0x99, x = a ^ b; otherwise k = 0xA1, x = a | b.
  - Then a' = b ^ c, b' = (c << 4) truncated to 8 bits, c' = x + k + W[i] mod 256.
  - Result: H0 = 0x01 + a, H1 = 0x89 + b, H2 = 0xFE + c, each mod 256.
- Pass condition: H0 < target AND H1 < target, unsigned. target = 0 never passes.
- FSM states:
  - IDLE: start goes to LOAD.
  - LOAD: build the window from the current nonce.
  - ROUND: runs 32/UNROLL cycles.
  - CHECK: updates hash_out, nonce_out, tries += 1 and found.
  - From CHECK: go to DONE on pass, mode = 0, tries = budget, or a pending abort. Otherwise nonce += 1 (wraps mod 2^(8*NONCE_BYTES)) and go to LOAD.
  - DONE: pulse done, return to IDLE.
- abort in LOAD/ROUND is latched and takes effect at the next CHECK; that attempt's result is still reported. If the pass condition and abort coincide, found = 1. abort in IDLE/DONE has no effect.
- start while busy is ignored; no queuing.
- reset low in any state: IDLE next edge; every output 0; any in-flight attempt is discarded.

## Timing
- Reset values: busy = done = found = 0; nonce_out = hash_out = tries = 0.
- Per-attempt cost is P = 32/UNROLL + 2 cycles (LOAD + ROUND + CHECK).
- Start sampled at edge 0 with N attempts: done is high after edge N*P + 1, for exactly one cycle.
- busy is high after edges 1 .. N*P and low in the done cycle.
- found, nonce_out, hash_out and tries change only at CHECK edges and are stable when done is high.
- start may be reasserted in the cycle after done; it is accepted from IDLE.

## Test plan
- Reset: hold reset = 0 for 3 cycles mid-search -> all outputs 0 next edge; the engine then accepts a fresh start.
- Budget exhaustion: mode = 1, target = 0x00, nonce_init = 0x00000010, max_tries = 5, UNROLL = 1 -> done after edge 171, found = 0, tries = 5, nonce_out = 0x00000014.
- Wrap: target = 0, nonce_init = 0xFFFFFFFF, max_tries = 3 -> successive nonces FFFFFFFF, 00000000, 00000001; nonce_out = 0x00000001, tries = 3.
- Single mode: mode = 0, random entry/nonce, target = 0x80, UNROLL in {1, 4} -> hash_out equals the behavioural model. found = (H0 < 0x80 && H1 < 0x80). tries = 1; done after edge P + 1 (35 or 11).
- Search hit: mode = 1, target = 0xFF, max_tries = 1000 -> nonce_out is the first nonce the model says passes, and found = 1. Start pulses issued during busy are ignored.
- Abort: mode = 1, target = 0, assert abort during the ROUND of attempt 3 -> done right after attempt 3's CHECK, tries = 3, found = 0.
